// File: rtl/sw_debounce.sv
// Per-channel switch synchronizer and debouncer with one-cycle rise/fall pulses.
// Optional build macro SW_DEBOUNCE_LATCH_EN turns o_sw into a push-on/push-off toggle.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_sw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;

  // Synchronizer chain; the last stage is the sampled level each FSM sees.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= i_sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State register: FSM, counter, debounced level and edge pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      deb_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      deb_q  <= deb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Next-state logic; a completed count flips the level and rearms the channel.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (s[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
              deb_d[i] = ~deb_q[i];
            end else begin
              state_d[i] = ST_COUNTING;
              cnt_d[i]   = cnt_q[i] + CNT_ONE;
            end
          end
        end
        ST_COUNTING: begin
          if (s[i] == deb_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            deb_d[i]   = ~deb_q[i];
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i]   = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Output logic; pulses register on the same edge the debounced level changes.
  always_comb begin
    rise_d = deb_d & ~deb_q;
    fall_d = ~deb_d & deb_q;
  end

  assign o_rise = rise_q;
  assign o_fall = fall_q;

`ifdef SW_DEBOUNCE_LATCH_EN
  logic [WIDTH-1:0] tog_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tog_q <= '0;
    end else begin
      tog_q <= tog_q ^ rise_d;
    end
  end

  assign o_sw = tog_q;
`else
  assign o_sw = deb_q;
`endif

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of independent switch channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer flop depth (legal 2..4).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), required stable cycles (legal >= 1).
REQ-004 SHALL have port clk  input  1  the single clock; all flops on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port i_sw  input  WIDTH  raw asynchronous switch levels.
REQ-007 SHALL have port o_sw  output  WIDTH  debounced switch state, registered; feeds the LED toggle stage's per-channel enables.
REQ-008 SHALL have port o_rise  output  WIDTH  one-cycle pulse per channel on debounced 0->1.
REQ-009 SHALL have port o_fall  output  WIDTH  one-cycle pulse per channel on debounced 1->0.

Function
REQ-010 SHALL pass each i_sw bit through its own SYNC_STAGES-deep flop chain; the last stage is the channel's sampled level s.
REQ-011 SHALL keep per channel a debounced level d and a counter of width $clog2(DEBOUNCE_CYCLES+1), never wrapping.
REQ-012 SHALL run per channel a two-state FSM: STABLE (s == d, counter 0) and COUNTING (s != d).
REQ-013 STABLE -> COUNTING when s != d; counter increments by 1 every cycle s != d.
REQ-014 COUNTING -> STABLE with counter cleared and d unchanged on any cycle s == d before the count completes (glitch rejected).
REQ-015 When counter == DEBOUNCE_CYCLES-1 and s != d, SHALL on that edge invert d, clear counter, return to STABLE.
REQ-016 Latency: a level held stable SHALL change d exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge sampling it; shorter pulses SHALL never change d.
REQ-017 o_rise[i]/o_fall[i] SHALL be high for exactly the one cycle after d[i] goes 0->1 / 1->0; never both high at once.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each behave per REQ-013..017.
REQ-019 o_sw SHALL equal d when SW_DEBOUNCE_LATCH_EN is undefined (see REQ-024).

Reset
REQ-020 While reset is high at a rising edge, SHALL clear all synchronizer flops, d, counters, and latch state to 0, FSMs to STABLE.
REQ-021 Reset values: o_sw = 0, o_rise = 0, o_fall = 0, held while reset is high.
REQ-022 Reset mid-count SHALL discard the partial count; after release, a high input needs the full REQ-016 latency again, producing an o_rise pulse.
REQ-023 Reset SHALL have no asynchronous effect; no output changes between clock edges.

Configuration
REQ-024 Macro SW_DEBOUNCE_LATCH_EN: when defined, o_sw[i] SHALL be a toggle latch inverting on each cycle o_rise[i] is high (push-on/push-off); when undefined, o_sw[i] = d[i] per REQ-019. o_rise/o_fall SHALL track d in both builds; port list unchanged.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8)
REQ-025 Reset 3 cycles with i_sw=4'hF -> o_sw, o_rise, o_fall all 0 during reset and at first post-reset edge.
REQ-026 i_sw[0] 0->1 held -> o_sw[0]=1 exactly 10 edges after first sampling edge, o_rise[0] high that one cycle only; later 1->0 -> o_sw[0]=0 after 10 edges with one o_fall[0] pulse.
REQ-027 i_sw[1] high 5 cycles then low; also bounce every 3 cycles for 30 cycles then stable high -> no change during glitch/bounce; exactly one o_rise[1], 10 edges after the final transition.
REQ-028 i_sw=4'hF at one edge with 4'h0 -> all four o_sw bits and o_rise bits assert on the same cycle; no cross-channel interaction.
REQ-029 reset asserted when channel 2 count = 5 -> o_sw[2]=0, no pulse; after release with i_sw[2] still high -> o_sw[2]=1 after full 10 edges.
REQ-030 SW_DEBOUNCE_LATCH_EN defined: two debounced press/release cycles on i_sw[3] -> o_sw[3] 0->1 on first o_rise[3], 1->0 on second, unchanged on o_fall[3].
